dyser_host_sequencer: RTL
=========================

# dyser_host_sequencer

Host-side master for the burst DySER 5x5 dual-port-output overlay. It drives the overlay's init, commit, send and receive interfaces from upstream valid/ready streams. Per run it streams a configuration image, pulses commit, then pushes operands to the single send port while collecting result pairs from the two receive ports. Both overlay stall signals are honoured. The block sits between the system/DMA side and the DySER top level.

## Interface
Parameters:
- DATA_W, 33: overlay data width (DATA_WIDTH+1).
- CNT_W, 16: width of the config-length and result-count fields.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- cfg_len  in  CNT_W  number of config words; latched on start.
- num_results  in  CNT_W  number of result pairs to collect; latched on start.
- rport0, rport1  in  5  receive port ids; latched on start.
- cfg_data  in  32  config word.
- cfg_valid  in  1  config word valid.
- cfg_ready  out  1  config word accepted.
- op_data  in  DATA_W  operand.
- op_port  in  5  operand port.
- op_valid  in  1  operand valid.
- op_ready  out  1  operand accepted.
- res_data0, res_data1  out  DATA_W  result pair.
- res_valid  out  1  result pair valid.
- res_ready  in  1  downstream accepts the result pair.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- config_bits  out  32  to overlay init.
- config_en  out  1  to overlay init.
- commit  out  1  to overlay commit.
- send_data_r0  out  DATA_W  to overlay send.
- send_port_r0  out  5  to overlay send.
- send_en0  out  1  to overlay send.
- send_stall  in  1  from overlay send.
- recv_port_r0, recv_port_r1  out  5  to overlay receive.
- recv_en0, recv_en1  out  1  to overlay receive.
- recv_data_r0, recv_data_r1  in  DATA_W  from overlay receive.
- recv_stall  in  1  from overlay receive.

## Operation
- FSM states: IDLE, CONFIG, COMMIT, RUN, DONE.
- IDLE:
  - start=1 latches cfg_len, num_results, rport0 and rport1.
  - Next state is CONFIG if cfg_len≠0, otherwise COMMIT.
  - start in any other state is ignored.
- CONFIG:
  - cfg_ready=1.
  - config_en = cfg_valid and config_bits = cfg_data, both combinational.
  - Each accepted word increments cfg_cnt.
  - When the word with cfg_cnt==cfg_len-1 is accepted, the next state is COMMIT.
- COMMIT:
  - commit=1 for exactly one cycle.
  - Next state is RUN if num_results≠0, otherwise DONE.
- RUN, send side:
  - send_en0 = op_valid; send_data_r0 and send_port_r0 pass through from op_data and op_port.
  - op_ready = op_valid & ~send_stall. The handshake completes in the cycle where both are high.
- RUN, receive side:
  - recv_port_r0/r1 = latched rport0/rport1.
  - recv_en0 = recv_en1 = (res_cnt<num_results) & (~res_valid | res_ready).
  - A pair is captured when recv_en0 & ~recv_stall. On capture, recv_data_r0/r1 load into res_data0/1, res_valid is set, and res_cnt increments.
  - res_valid clears on res_ready unless a new capture happens in the same cycle.
- RUN to DONE: when res_cnt reaches num_results and res_valid is clear, or is being cleared this cycle.
- Operands left unsent at that point stay pending; op_ready=0 outside RUN.
- DONE: done=1 for one cycle, then IDLE.
- Outside RUN: all overlay enables are 0. Outside CONFIG: cfg_ready=0.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and all counters and latches are 0. A reset mid-run aborts immediately with no commit and no done.
- start at cycle t puts the FSM in CONFIG/COMMIT at t+1.
- Config throughput is one word per cycle. commit rises the cycle after the last config word.
- Send: zero-latency pass-through, up to one operand per cycle.
- Receive: res_valid rises one cycle after capture. With res_ready held high, throughput is one pair per cycle.
- done rises one cycle after the final result handshake.
- Boundaries:
  - cfg_len=0 gives IDLE→COMMIT→RUN.
  - num_results=0 gives COMMIT→DONE.
  - recv_stall held high keeps recv_en asserted and leaves res_data unchanged.
  - Send and receive proceed independently in the same cycle.

## Structure
- Package dyser_host_pkg holds:
  - the state enum;
  - the port-id width (5);
  - the config word width (32);
  - default DATA_W and CNT_W.
- Sub-module dyser_result_hold: a 1-entry valid/ready register slice for the result pair, which generates the receive enable condition.

## Test plan
- cfg_len=3, words 0xA1/0xA2/0xA3 with cfg_valid gapped every other cycle → exactly 3 config_en pulses carrying those values, then one commit pulse.
- cfg_len=0, num_results=0 → commit one cycle after start, done the cycle after commit, busy low afterwards.
- RUN with op stream of port 2/7/9 and send_stall high for 2 cycles on the second operand → send order preserved, op_ready low during the stall, no operand duplicated.
- num_results=4, recv_stall low, res_ready pulsed every third cycle → 4 pairs delivered in order, with no capture while the holding slice is full, then done.
- recv_stall high for 5 cycles → recv_en0/1 stay high, res_valid stays 0, res_cnt is unchanged.
- rst asserted mid-RUN → all outputs 0 on the same edge, and the next start runs cleanly.

Source files
------------

// File: rtl/dyser_host_pkg.sv
// Purpose : shared widths, defaults and FSM encoding for the DySER host sequencer.
// Latency : n/a (declarations only).
// Backpres: n/a.
package dyser_host_pkg;

   localparam int PORT_W     = 5;    // overlay port id width
   localparam int CFG_W      = 32;   // overlay configuration word width
   localparam int DEF_DATA_W = 33;   // overlay data width (DATA_WIDTH+1)
   localparam int DEF_CNT_W  = 16;   // config-length / result-count width

   // Sequencer FSM encoding, kept as plain constants so older tools can consume it.
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_CONFIG = 3'd1;
   localparam state_t ST_COMMIT = 3'd2;
   localparam state_t ST_RUN    = 3'd3;
   localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/dyser_host_sequencer_if.sv
// Purpose : bundle of the overlay-facing init/commit/send/receive signals.
// Latency : n/a (wires only).
// Backpres: send_stall / recv_stall flow from overlay to sequencer.
// Modports: master = host sequencer side, slave = overlay side.
interface dyser_host_sequencer_if
   import dyser_host_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);

   logic [CFG_W-1:0]  config_bits;
   logic              config_en;
   logic              commit;
   logic [DATA_W-1:0] send_data_r0;
   logic [PORT_W-1:0] send_port_r0;
   logic              send_en0;
   logic              send_stall;
   logic [PORT_W-1:0] recv_port_r0;
   logic [PORT_W-1:0] recv_port_r1;
   logic              recv_en0;
   logic              recv_en1;
   logic [DATA_W-1:0] recv_data_r0;
   logic [DATA_W-1:0] recv_data_r1;
   logic              recv_stall;

   modport master (
      output config_bits, config_en, commit,
      output send_data_r0, send_port_r0, send_en0,
      input  send_stall,
      output recv_port_r0, recv_port_r1, recv_en0, recv_en1,
      input  recv_data_r0, recv_data_r1, recv_stall
   );

   modport slave (
      input  config_bits, config_en, commit,
      input  send_data_r0, send_port_r0, send_en0,
      output send_stall,
      input  recv_port_r0, recv_port_r1, recv_en0, recv_en1,
      output recv_data_r0, recv_data_r1, recv_stall
   );

endinterface

// File: rtl/dyser_result_hold.sv
// Purpose : 1-entry valid/ready holding register for an overlay result pair.
// Latency : res_valid rises 1 cycle after capture; 1 pair/cycle with res_ready high.
// Backpres: recv_en drops while the slot is full and not draining; recv_stall blocks capture.
// Ports   : avail (more results wanted), recv_stall/recv_data0/1 from overlay,
//           recv_en/capture to sequencer, res_valid/res_data0/1/res_ready downstream.
module dyser_result_hold #(
   parameter int DATA_W = 33
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              avail,
   input  logic              recv_stall,
   input  logic [DATA_W-1:0] recv_data0,
   input  logic [DATA_W-1:0] recv_data1,
   output logic              recv_en,
   output logic              capture,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data0,
   output logic [DATA_W-1:0] res_data1,
   input  logic              res_ready
);

   logic              res_valid_q, res_valid_d;
   logic [DATA_W-1:0] res_data0_q, res_data0_d;
   logic [DATA_W-1:0] res_data1_q, res_data1_d;

   // Slot can accept when empty or when its current pair leaves this cycle.
   assign recv_en = avail & (~res_valid_q | res_ready);
   assign capture = recv_en & ~recv_stall;

   always_comb begin
      res_valid_d = res_valid_q;
      res_data0_d = res_data0_q;
      res_data1_d = res_data1_q;
      if (capture) begin
         res_valid_d = 1'b1;
         res_data0_d = recv_data0;
         res_data1_d = recv_data1;
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid_q <= 1'b0;
         res_data0_q <= '0;
         res_data1_q <= '0;
      end else begin
         res_valid_q <= res_valid_d;
         res_data0_q <= res_data0_d;
         res_data1_q <= res_data1_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data0 = res_data0_q;
   assign res_data1 = res_data1_q;

endmodule

// File: rtl/dyser_host_sequencer.sv
// Purpose : host master for the DySER overlay: config stream, commit pulse, operand send, result receive.
// Latency : config/send are zero-latency pass-through; results 1 cycle after capture; done 1 cycle after last result.
// Backpres: cfg_ready only in CONFIG; op_ready follows send_stall; result slot stalls recv_en; recv_stall blocks capture.
// Ports   : start/cfg_len/num_results/rport0/1 (run setup), cfg_* (config stream), op_* (operand stream),
//           res_* (result pair stream), busy/done (status), ovl (overlay bundle, master side).
module dyser_host_sequencer
   import dyser_host_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  cfg_len,
   input  logic [CNT_W-1:0]  num_results,
   input  logic [PORT_W-1:0] rport0,
   input  logic [PORT_W-1:0] rport1,
   input  logic [CFG_W-1:0]  cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [DATA_W-1:0] op_data,
   input  logic [PORT_W-1:0] op_port,
   input  logic              op_valid,
   output logic              op_ready,
   output logic [DATA_W-1:0] res_data0,
   output logic [DATA_W-1:0] res_data1,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              busy,
   output logic              done,
   dyser_host_sequencer_if.master ovl
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cfg_len_q, cfg_len_d;
   logic [CNT_W-1:0]  num_res_q, num_res_d;
   logic [CNT_W-1:0]  cfg_cnt_q, cfg_cnt_d;
   logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
   logic [PORT_W-1:0] rport0_q, rport0_d;
   logic [PORT_W-1:0] rport1_q, rport1_d;

   logic in_config, in_run;
   logic cfg_acc, cfg_last;
   logic res_avail, recv_en, capture, run_done;

   assign in_config = (state_q == ST_CONFIG);
   assign in_run    = (state_q == ST_RUN);
   assign cfg_acc   = in_config & cfg_valid;
   assign cfg_last  = cfg_acc & (cfg_cnt_q == (cfg_len_q - CNT_W'(1)));
   assign res_avail = in_run & (res_cnt_q < num_res_q);

   dyser_result_hold #(
      .DATA_W (DATA_W)
   ) u_hold (
      .clk        (clk),
      .rst        (rst),
      .avail      (res_avail),
      .recv_stall (ovl.recv_stall),
      .recv_data0 (ovl.recv_data_r0),
      .recv_data1 (ovl.recv_data_r1),
      .recv_en    (recv_en),
      .capture    (capture),
      .res_valid  (res_valid),
      .res_data0  (res_data0),
      .res_data1  (res_data1),
      .res_ready  (res_ready)
   );

   // All results counted and the slot is empty or draining this cycle.
   // No capture can coincide because res_avail is low once the count is reached.
   assign run_done = (res_cnt_q == num_res_q) & (~res_valid | res_ready);

   always_comb begin
      state_d   = state_q;
      cfg_len_d = cfg_len_q;
      num_res_d = num_res_q;
      cfg_cnt_d = cfg_cnt_q;
      res_cnt_d = res_cnt_q;
      rport0_d  = rport0_q;
      rport1_d  = rport1_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cfg_len_d = cfg_len;
               num_res_d = num_results;
               rport0_d  = rport0;
               rport1_d  = rport1;
               cfg_cnt_d = '0;
               res_cnt_d = '0;
               state_d   = (cfg_len != '0) ? ST_CONFIG : ST_COMMIT;
            end
         end
         ST_CONFIG: begin
            if (cfg_acc) begin
               cfg_cnt_d = cfg_cnt_q + CNT_W'(1);
            end
            if (cfg_last) begin
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            state_d = (num_res_q != '0) ? ST_RUN : ST_DONE;
         end
         ST_RUN: begin
            if (capture) begin
               res_cnt_d = res_cnt_q + CNT_W'(1);
            end
            if (run_done) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cfg_len_q <= '0;
         num_res_q <= '0;
         cfg_cnt_q <= '0;
         res_cnt_q <= '0;
         rport0_q  <= '0;
         rport1_q  <= '0;
      end else begin
         state_q   <= state_d;
         cfg_len_q <= cfg_len_d;
         num_res_q <= num_res_d;
         cfg_cnt_q <= cfg_cnt_d;
         res_cnt_q <= res_cnt_d;
         rport0_q  <= rport0_d;
         rport1_q  <= rport1_d;
      end
   end

   // Data/port buses are gated to zero outside their phase so idle overlay inputs stay quiet.
   assign cfg_ready        = in_config;
   assign ovl.config_en    = cfg_acc;
   assign ovl.config_bits  = in_config ? cfg_data : '0;
   assign ovl.commit       = (state_q == ST_COMMIT);

   assign ovl.send_en0     = in_run & op_valid;
   assign ovl.send_data_r0 = in_run ? op_data : '0;
   assign ovl.send_port_r0 = in_run ? op_port : '0;
   assign op_ready         = in_run & op_valid & ~ovl.send_stall;

   assign ovl.recv_port_r0 = in_run ? rport0_q : '0;
   assign ovl.recv_port_r1 = in_run ? rport1_q : '0;
   assign ovl.recv_en0     = recv_en;
   assign ovl.recv_en1     = recv_en;

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);

endmodule
